// File: rtl/i2s_receiver.sv
// Purpose : slave-mode I2S deserializer, serial stream -> parallel left/right words, with lock tracking.
// Latency : new pair and sample_valid appear the cycle after the 1->0 word_select edge that closes the frame.
// Backpr. : none; the serial master cannot be stalled, so each frame is presented once and then overwritten.
//
// Ports:
//   s_clk        - serial bit clock (only clock); reset - async active-low
//   word_select  - I2S WS (0 = left, 1 = right); sound_bit_in - I2S serial data, MSB first
//   left_sample / right_sample - last complete pair, SILENCE while unlocked
//   sample_valid - one-cycle pulse per delivered pair; length_error - pulses with it on a bad half length
//   locked       - high from the cycle after the first delivered pair until timeout or reset
module i2s_receiver #(
  parameter int                      SAMPLE_WIDTH   = 12,
  parameter int                      EXPECTED_BITS  = 13,
  parameter int                      TIMEOUT_CYCLES = 64,
  parameter logic [SAMPLE_WIDTH-1:0] SILENCE        = 12'h800
) (
  input  logic                    s_clk,
  input  logic                    reset,
  input  logic                    word_select,
  input  logic                    sound_bit_in,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    sample_valid,
  output logic                    locked,
  output logic                    length_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] LEFT     = 2'd1;
  localparam logic [1:0] RIGHT    = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    ws_q, ws_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                    len_l_q, len_l_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                    valid_q, valid_d;
  logic                    locked_q, locked_d;
  logic                    lenerr_q, lenerr_d;

  logic                    ws_edge, ws_rise, ws_fall;
  logic                    timeout;
  logic                    len_bad;
  logic [SAMPLE_WIDTH-1:0] word_now;

  assign ws_d    = word_select;
  assign ws_edge = (word_select != ws_q);
  assign ws_rise = ws_edge & ~ws_q;
  assign ws_fall = ws_edge &  ws_q;

  // cnt_q counts bits of the current half already seen; the bit arriving in an
  // edge cycle still belongs to the old word, so that half's length is cnt_q + 1.
  assign len_bad = (cnt_q != CW'(EXPECTED_BITS - 1));

  // Timeout fires on the cycle the counter would reach TIMEOUT_CYCLES; a
  // coincident edge takes priority.
  assign timeout = (state_q != UNLOCKED) && !ws_edge && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

  // Word including this cycle's bit; bits are placed left-aligned so a short
  // half leaves its unfilled LSBs at zero and bits past SAMPLE_WIDTH drop out.
  always_comb begin
    word_now = shift_q;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (int'(cnt_q) == SAMPLE_WIDTH - 1 - i) begin
        word_now[i] = sound_bit_in;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ws_edge) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end
    shift_d = ws_edge ? '0 : word_now;
  end

  always_comb begin
    state_d     = state_q;
    left_hold_d = left_hold_q;
    len_l_d     = len_l_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    lenerr_d    = 1'b0;
    case (state_q)
      UNLOCKED: begin
        // Only a right->left transition marks a frame start; anything before it is partial.
        if (ws_fall) state_d = LEFT;
      end
      LEFT: begin
        if (ws_rise) begin
          left_hold_d = word_now;
          len_l_d     = len_bad;
          state_d     = RIGHT;
        end else if (timeout) begin
          state_d = UNLOCKED;
          left_d  = SILENCE;
          right_d = SILENCE;
        end
      end
      RIGHT: begin
        if (ws_fall) begin
          left_d   = left_hold_q;
          right_d  = word_now;
          valid_d  = 1'b1;
          lenerr_d = len_l_q | len_bad;
          state_d  = LEFT;
        end else if (timeout) begin
          state_d = UNLOCKED;
          left_d  = SILENCE;
          right_d = SILENCE;
        end
      end
      default: begin
        state_d = UNLOCKED;
        left_d  = SILENCE;
        right_d = SILENCE;
      end
    endcase
    // Lock is declared only once a whole frame has been delivered.
    locked_d = (state_d != UNLOCKED) && (locked_q || valid_q);
  end

  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= UNLOCKED;
      ws_q        <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      len_l_q     <= 1'b0;
      left_q      <= SILENCE;
      right_q     <= SILENCE;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      lenerr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      len_l_q     <= len_l_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      lenerr_q    <= lenerr_d;
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign length_error = lenerr_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Purpose : directed bench for i2s_receiver: framing, lock, timeout, length errors, resets.
// Latency : expects the pair and sample_valid one cycle after the closing 1->0 WS edge.
// Backpr. : none; the bench plays the I2S master and drives one bit per s_clk.
module tb_i2s_receiver;

  logic        s_clk = 1'b0;
  logic        reset;
  logic        word_select;
  logic        sound_bit_in;
  logic [11:0] left_sample;
  logic [11:0] right_sample;
  logic        sample_valid;
  logic        locked;
  logic        length_error;

  i2s_receiver dut (
    .s_clk        (s_clk),
    .reset        (reset),
    .word_select  (word_select),
    .sound_bit_in (sound_bit_in),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .locked       (locked),
    .length_error (length_error)
  );

  always #5 s_clk = ~s_clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc;
  int   nvalid;
  int   first_valid_cyc;
  int   last_valid_cyc;
  logic lock_at_first;
  logic lenerr_last;
  logic stray_lenerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tracking();
    cyc             = 0;
    nvalid          = 0;
    first_valid_cyc = -1;
    last_valid_cyc  = -1;
    lock_at_first   = 1'b0;
    lenerr_last     = 1'b0;
    stray_lenerr    = 1'b0;
  endtask

  // One serial bit: drive, clock, then observe 1 time unit after the edge.
  task automatic tick(input logic ws, input logic d);
    word_select  = ws;
    sound_bit_in = d;
    @(posedge s_clk);
    #1;
    if (sample_valid) begin
      if (nvalid == 0) begin
        first_valid_cyc = cyc;
        lock_at_first   = locked;
      end
      last_valid_cyc = cyc;
      lenerr_last    = length_error;
      nvalid++;
    end else if (length_error) begin
      stray_lenerr = 1'b1;
    end
    cyc++;
  endtask

  // n cycles with constant WS. Slot 0 is the edge cycle (old word's last slot,
  // driven 0); slots 1..12 carry word MSB first; later slots are 0.
  task automatic send_half(input logic ws, input logic [11:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      logic d;
      d = (i >= 1 && i <= 12) ? word[12 - i] : 1'b0;
      tick(ws, d);
    end
  endtask

  initial begin
    reset        = 1'b0;
    word_select  = 1'b0;
    sound_bit_in = 1'b0;
    clear_tracking();
    repeat (3) @(posedge s_clk);
    #1;
    chk("reset_left",   left_sample,  12'h800);
    chk("reset_right",  right_sample, 12'h800);
    chk("reset_valid",  sample_valid, 1'b0);
    chk("reset_locked", locked,       1'b0);
    chk("reset_lenerr", length_error, 1'b0);

    // Basic frames: idle cyc 0..2, frames start at 3, 29, 55; closing edge at 81.
    reset = 1'b1;
    clear_tracking();
    repeat (3) tick(1'b0, 1'b0);
    repeat (3) begin
      send_half(1'b0, 12'hA5C, 13);
      send_half(1'b1, 12'h3F1, 13);
    end
    tick(1'b0, 1'b0);
    chk("basic_nvalid",      nvalid,                         2);
    chk("basic_first_cyc",   first_valid_cyc,                55);
    chk("basic_spacing",     last_valid_cyc - first_valid_cyc, 26);
    chk("basic_left",        left_sample,                    12'hA5C);
    chk("basic_right",       right_sample,                   12'h3F1);
    chk("basic_lenerr",      lenerr_last,                    1'b0);
    chk("basic_lock_at_vld", lock_at_first,                  1'b0);
    chk("basic_locked",      locked,                         1'b1);

    // Timeout: 63 quiet cycles after the edge keep lock, the 64th drops it.
    repeat (63) tick(1'b0, 1'b0);
    chk("timeout_still_locked", locked, 1'b1);
    tick(1'b0, 1'b0);
    chk("timeout_locked", locked,       1'b0);
    chk("timeout_left",   left_sample,  12'h800);
    chk("timeout_right",  right_sample, 12'h800);
    chk("timeout_nvalid", nvalid,       2);

    // Relock: the 0->1 edge is ignored, the next 1->0 edge starts a frame.
    clear_tracking();
    repeat (5) tick(1'b1, 1'b0);
    send_half(1'b0, 12'h111, 13);
    chk("relock_pre_left",   left_sample, 12'h800);
    chk("relock_pre_nvalid", nvalid,      0);
    send_half(1'b1, 12'h222, 13);
    send_half(1'b0, 12'h333, 13);
    send_half(1'b1, 12'h444, 13);
    send_half(1'b0, 12'h555, 13);
    chk("relock_nvalid", nvalid,       2);
    chk("relock_left",   left_sample,  12'h333);
    chk("relock_right",  right_sample, 12'h444);
    chk("relock_locked", locked,       1'b1);

    // Mid-word reset during a right word.
    send_half(1'b1, 12'h666, 7);
    reset = 1'b0;
    #2;
    chk("mwreset_left",   left_sample,  12'h800);
    chk("mwreset_right",  right_sample, 12'h800);
    chk("mwreset_locked", locked,       1'b0);
    chk("mwreset_valid",  sample_valid, 1'b0);
    @(posedge s_clk);
    #1;
    reset = 1'b1;
    clear_tracking();
    send_half(1'b1, 12'h666, 6);
    send_half(1'b0, 12'h777, 13);
    send_half(1'b1, 12'h888, 13);
    chk("mwreset_pre_nvalid", nvalid,      0);
    chk("mwreset_pre_left",   left_sample, 12'h800);
    send_half(1'b0, 12'h999, 13);
    chk("mwreset_first_cyc", first_valid_cyc, 32);
    chk("mwreset_out_left",  left_sample,     12'h777);
    chk("mwreset_out_right", right_sample,    12'h888);
    chk("mwreset_relocked",  locked,          1'b1);

    // Mid-frame start: stream begins 5 cycles into a right half.
    reset = 1'b0;
    word_select = 1'b0;
    @(posedge s_clk);
    #1;
    reset = 1'b1;
    clear_tracking();
    send_half(1'b1, 12'hABC, 8);
    send_half(1'b0, 12'h135, 13);
    send_half(1'b1, 12'h246, 13);
    chk("midframe_nvalid", nvalid,       0);
    chk("midframe_left",   left_sample,  12'h800);
    chk("midframe_right",  right_sample, 12'h800);

    // Short halves (10 cycles): the closing edge of this half delivers 135/246.
    send_half(1'b0, 12'hFFF, 10);
    chk("midframe_out_nvalid", nvalid,       1);
    chk("midframe_out_left",   left_sample,  12'h135);
    chk("midframe_out_right",  right_sample, 12'h246);
    chk("midframe_out_lenerr", lenerr_last,  1'b0);
    send_half(1'b1, 12'h5A5, 10);
    send_half(1'b0, 12'h123, 16);
    chk("short_left",   left_sample,  12'hFF8);
    chk("short_right",  right_sample, 12'h5A0);
    chk("short_lenerr", lenerr_last,  1'b1);

    // Long halves (16 cycles).
    send_half(1'b1, 12'hEDC, 16);
    send_half(1'b0, 12'h000, 13);
    chk("long_left",   left_sample,  12'h123);
    chk("long_right",  right_sample, 12'hEDC);
    chk("long_lenerr", lenerr_last,  1'b1);
    chk("long_nvalid", nvalid,       3);
    chk("stray_lenerr", stray_lenerr, 1'b0);
    chk("long_locked", locked,       1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Slave-mode I2S deserializer for the capture path: ADC/codec serial stream -> parallel 12-bit left/right samples.
- Feeds the playback transmitter: left_sample drives its sound_in, and sample_valid marks frame boundaries.
- Same s_clk domain as the transmitter. The external master drives word_select and serial data, both sampled on rising s_clk.
- Provides lock detection, word-length checking and silence substitution on loss of lock.

Parameters:
- SAMPLE_WIDTH, 12, bits captured per channel word (MSB first).
- EXPECTED_BITS, 13, s_clk cycles per half-frame; any other count flags a length error.
- TIMEOUT_CYCLES, 64, cycles with no word_select edge before lock is dropped.
- SILENCE, 12'h800, sample value output at reset and while unlocked (offset-binary midscale).

Ports:
- s_clk  input  1  serial bit clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- word_select  input  1  I2S WS from master: 0 = left, 1 = right.
- sound_bit_in  input  1  I2S serial data.
- left_sample  output  SAMPLE_WIDTH  last complete left word.
- right_sample  output  SAMPLE_WIDTH  last complete right word.
- sample_valid  output  1  one-cycle pulse when a new left/right pair is presented.
- locked  output  1  high while frame alignment is held.
- length_error  output  1  one-cycle pulse with sample_valid if either half's bit count != EXPECTED_BITS.

Behaviour:
- Registering: word_select and sound_bit_in are registered every cycle into ws_q and sd.
- Edge detection: an edge cycle is any cycle where the sampled word_select != ws_q.
- Half-word membership (1-bit I2S delay): a half-word is the sd samples from edge+1 through the next edge cycle inclusive. The sd sampled in an edge cycle belongs to the OLD word.
- Capture: the first SAMPLE_WIDTH bits of a half-word shift in MSB-first. Later bits are ignored.
- Short word: if fewer than SAMPLE_WIDTH bits arrive, the unfilled LSBs are zero.
- Bit counter: counts cycles per half-word, saturates at TIMEOUT_CYCLES, and is cleared on each edge.
- FSM states: UNLOCKED, LEFT, RIGHT.
- UNLOCKED:
  - locked=0, outputs held at SILENCE.
  - Waits for a 1->0 edge, then goes to LEFT. A 0->1 edge is ignored.
  - No sample_valid is ever produced from the partial frame preceding lock.
- LEFT:
  - On a 0->1 edge, latch the captured word into the internal left holding register and go to RIGHT.
  - A 1->0 edge here is impossible. Any counter saturation -> UNLOCKED.
- RIGHT:
  - On a 1->0 edge, latch right and transfer both holding words to left_sample/right_sample.
  - Pulse sample_valid for exactly one cycle, then go to LEFT.
  - Latency: outputs and pulse are visible in the cycle after the edge cycle.
- Lock indication: locked rises in the cycle after the first complete frame's sample_valid, not on entry to LEFT.
- length_error: evaluated from both halves' counts; asserted in the same cycle as sample_valid. The frame is still delivered.
- Timeout: counter reaching TIMEOUT_CYCLES in LEFT or RIGHT moves the FSM to UNLOCKED.
  - locked=0 next cycle; left_sample and right_sample are set to SILENCE.
  - The in-progress partial frame is discarded.
- Reset (async assert, including mid-word):
  - left_sample = right_sample = SILENCE; sample_valid = locked = length_error = 0.
  - FSM = UNLOCKED; counters, shift register, ws_q and sd cleared to 0.
  - After release, relock requires a fresh 1->0 edge.
- Simultaneous events: an edge in the same cycle as counter saturation counts as an edge; the timeout is ignored.
- Output stability: outputs are stable between sample_valid pulses.

Test Plan:
- Basic frames: release reset; stream three 26-cycle frames with left=0xA5C, right=0x3F1, 13 cycles per half -> first sample_valid one cycle after the second 1->0 edge, carrying left_sample=0xA5C and right_sample=0x3F1. length_error=0. locked=1 thereafter. Pulses are spaced exactly 26 cycles apart.
- Mid-frame start: begin the stream 5 cycles into a right half -> no sample_valid until one full left+right pair completes. Outputs stay at 0x800.
- Short halves: 10 cycles per half with left word 0xFFF (9 data bits captured) -> left_sample=0xFF8, length_error pulses with sample_valid.
- Long halves: 16 cycles per half -> only the first 12 bits are captured and words are correct. length_error=1.
- Timeout: hold word_select=0 for 64 cycles while locked -> locked=0 the next cycle, samples=0x800, no sample_valid. A new 1->0 edge plus a complete frame relocks.
- Mid-word reset: assert reset during bit 6 of a right word -> immediate SILENCE outputs and locked=0. After release, the first valid frame comes only after a fresh 1->0 edge plus a complete frame.
